mem_access_stg: RTL
===================

// Module: mem_access_stg
// PURPOSE
// - Memory-access stage of the 6-stage 16-bit pipeline. Sits between EX and write_back_stg.
// - Holds the EX/MEM pipeline register and performs loads and stores on the data memory
//   through a req/ack handshake. Stalls upstream while an access is outstanding.
// - Produces the data, write enable and register address that write_back_stg consumes.
// PARAMETERS
// - DATA_W   16   datapath width
// - ADDR_W   16   data-memory address width
// - RF_AW    3    register-file address width
// - TIMEOUT  15   max wait cycles for dmem_ack before the access is aborted (>=1)
// PORTS
// - clk            in   1       clock, rising edge
// - reset          in   1       asynchronous, active-low reset (0 = reset)
// - ex_valid       in   1       EX presents an instruction this cycle
// - ex_alu_result  in   DATA_W  ALU result; also the memory address for loads/stores
// - ex_store_data  in   DATA_W  store data
// - ex_mem_rd      in   1       instruction is a load
// - ex_mem_wr      in   1       instruction is a store (ex_mem_rd and ex_mem_wr both 1 = treat as load)
// - ex_wb_en       in   1       instruction writes the register file
// - ex_rf_writea   in   RF_AW   destination register
// - flush          in   1       squash the instruction being captured this cycle
// - mem_stall      out  1       upstream must hold its outputs; EX/MEM is not updated
// - dmem_req       out  1       memory request, held until ack or abort
// - dmem_we        out  1       1 = write, 0 = read
// - dmem_addr      out  ADDR_W  = latched ALU result [ADDR_W-1:0]
// - dmem_wdata     out  DATA_W  = latched store data
// - dmem_rdata     in   DATA_W  read data, valid when dmem_ack=1
// - dmem_ack       in   1       access complete; may be high in the same cycle as the request
// - wb_data        out  DATA_W  to write_back_stg inp_data
// - wb_en_out      out  1       to write_back_stg wb_en_in
// - rf_writea_out  out  RF_AW   to write_back_stg rf_writea_wbin
// - mem_err        out  1       one-cycle pulse when an access is aborted on timeout
// BEHAVIOUR
// - Reset (reset=0, async): all registers cleared, FSM = S_IDLE, wait counter = 0.
//   All outputs read 0, including mem_stall and dmem_req.
// - EX/MEM register
//   - Loads on a clock edge when mem_stall=0.
//   - Valid bit = ex_valid & ~flush.
//   - flush while mem_stall=1 has no effect.
// - Latched op is memory-type when valid & (mem_rd | mem_wr).
//   - Non-memory valid op: next edge, wb_data = alu_result, wb_en_out = wb_en. Latency 1.
//   - Invalid op: bubble, wb_en_out = 0.
// - dmem_req = memory-type latched op & state != S_DONE.
//   - dmem_we/addr/wdata are stable for the whole request.
// - mem_stall = dmem_req & ~dmem_ack & ~timeout_hit.
// - FSM:
//   - S_IDLE: memory op and ack -> complete, stay S_IDLE. Memory op without ack -> S_WAIT, counter = 1.
//   - S_WAIT: ack -> complete, S_IDLE, counter = 0.
//     counter == TIMEOUT without ack -> abort: mem_err pulse, wb_en_out = 0, S_IDLE.
//     Otherwise counter++.
//   - Counter is saturating and never wraps.
//   - timeout_hit = (state == S_WAIT) & (counter == TIMEOUT) & ~dmem_ack.
//     If ack and timeout coincide, ack wins.
// - Completion writes MEM/WB on that edge:
//   - Load: wb_data = dmem_rdata, wb_en_out = wb_en.
//   - Store: wb_data = alu_result, wb_en_out = 0 (forced).
// - While stalled, MEM/WB takes a bubble each cycle: wb_en_out = 0, data/addr hold.
// - Back-to-back: the new EX op is captured on the completion edge, so zero-wait memory
//   gives one instruction per cycle.
// - Reset mid-access drops the access; dmem_req falls immediately (async).
// STRUCTURE
// - Shared package/header pipe_pkg:
//   - state encodings S_IDLE / S_WAIT / S_DONE (S_DONE reserved, unused)
//   - DATA_W / RF_AW defaults
//   - memop type constants
// - Single module; no sub-module needed.
//   The EX/MEM register, FSM and counter, and MEM/WB register are three always blocks.
// TESTING
// - Reset: drive reset=0 mid-run -> every output 0 within the same cycle; FSM S_IDLE after release.
// - ALU op: ex_alu_result=16'h1234, wb_en=1, rf=3'd5
//   -> one cycle later wb_data=16'h1234, wb_en_out=1, rf_writea_out=5, no dmem_req.
// - Zero-wait load: addr 16'h0040, ack same cycle, rdata=16'hBEEF
//   -> mem_stall never 1, next edge wb_data=16'hBEEF, wb_en_out=1.
// - 3-cycle load: ack after 3 cycles -> mem_stall=1 for 3 cycles, three bubbles (wb_en_out=0),
//   EX inputs ignored, then wb_data=rdata.
// - Store with wb_en=1: dmem_we=1, addr/wdata held until ack, wb_en_out=0 afterwards.
// - Timeout: TIMEOUT=4, no ack -> after 4 wait cycles mem_err pulses once, wb_en_out=0,
//   mem_stall drops, next instruction proceeds.
// - Flush during stall ignored; flush with stall=0 -> captured op becomes a bubble.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the 16-bit pipeline: FSM state encodings, default
// widths and the memory-operation classification used by the MEM stage.
package pipe_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int ADDR_W_DEF  = 16;
    localparam int RF_AW_DEF   = 3;
    localparam int TIMEOUT_DEF = 15;

    // Memory-access FSM states. S_DONE is reserved and never entered.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Kind of data-memory operation held in the EX/MEM register.
    typedef enum logic [1:0] {
        MEMOP_NONE  = 2'd0,
        MEMOP_LOAD  = 2'd1,
        MEMOP_STORE = 2'd2
    } memop_t;

    // Classify an incoming instruction. Read wins when both read and write
    // are set, and an invalid slot is never a memory operation.
    function automatic memop_t decode_memop(input logic valid,
                                            input logic rd,
                                            input logic wr);
        memop_t op;
        op = MEMOP_NONE;
        if (valid && rd) begin
            op = MEMOP_LOAD;
        end else if (valid && wr) begin
            op = MEMOP_STORE;
        end
        return op;
    endfunction

endpackage

// File: rtl/mem_access_stg.sv
// Memory-access stage: EX/MEM pipeline register, data-memory req/ack
// sequencer with abort-on-timeout, and the MEM/WB register feeding
// write_back_stg. Upstream is stalled while an access is outstanding.
//
// Data-memory handshake: dmem_req is raised while a valid load/store sits
// in EX/MEM and stays high, with dmem_we/addr/wdata stable, until a cycle
// in which dmem_ack=1 (the transfer completes on that clock edge, and ack
// may already be high in the first request cycle) or until the wait
// counter reaches TIMEOUT without ack (the access is abandoned on that edge
// and mem_err pulses for one cycle). An ack and a timeout in the same cycle
// count as a completion.
module mem_access_stg
    import pipe_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int RF_AW   = RF_AW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic              ex_mem_rd,
    input  logic              ex_mem_wr,
    input  logic              ex_wb_en,
    input  logic [RF_AW-1:0]  ex_rf_writea,
    input  logic              flush,
    output logic              mem_stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_en_out,
    output logic [RF_AW-1:0]  rf_writea_out,
    output logic              mem_err,
    output logic [1:0]        fsm_state
);

    // Counter only needs to reach TIMEOUT; it saturates there.
    localparam int               CNT_W     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // EX/MEM register contents
    logic              em_valid;
    memop_t            em_op;
    logic [DATA_W-1:0] em_alu;
    logic [DATA_W-1:0] em_sdata;
    logic              em_wb_en;
    logic [RF_AW-1:0]  em_rf;

    // Access sequencer
    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  wait_cnt_nx;
    logic              timeout_hit;
    logic              mem_op;

    assign mem_op      = (em_op != MEMOP_NONE);
    assign dmem_req    = mem_op && (state != S_DONE);
    assign dmem_we     = (em_op == MEMOP_STORE);
    assign dmem_addr   = em_alu[ADDR_W-1:0];
    assign dmem_wdata  = em_sdata;
    assign timeout_hit = (state == S_WAIT) && (wait_cnt == CNT_LIMIT) && !dmem_ack;
    assign mem_stall   = dmem_req && !dmem_ack && !timeout_hit;
    assign fsm_state   = state;

    // EX/MEM register: capture the EX instruction whenever the stage is not stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            em_valid <= 1'b0;
            em_op    <= MEMOP_NONE;
            em_alu   <= '0;
            em_sdata <= '0;
            em_wb_en <= 1'b0;
            em_rf    <= '0;
        end else if (!mem_stall) begin
            em_valid <= ex_valid && !flush;
            em_op    <= decode_memop(ex_valid && !flush, ex_mem_rd, ex_mem_wr);
            em_alu   <= ex_alu_result;
            em_sdata <= ex_store_data;
            em_wb_en <= ex_wb_en;
            em_rf    <= ex_rf_writea;
        end
    end

    // Sequencer state, wait counter and the registered timeout error pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
            mem_err  <= timeout_hit;
        end
    end

    // Next state: wait for ack, counting cycles, and give up at TIMEOUT.
    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        unique case (state)
            S_IDLE: begin
                if (dmem_req && !dmem_ack) begin
                    state_nx    = S_WAIT;
                    wait_cnt_nx = CNT_ONE;
                end
            end
            S_WAIT: begin
                if (dmem_ack || timeout_hit) begin
                    state_nx    = S_IDLE;
                    wait_cnt_nx = '0;
                end else if (wait_cnt != CNT_LIMIT) begin
                    wait_cnt_nx = wait_cnt + CNT_ONE;
                end
            end
            default: begin
                state_nx    = S_IDLE;
                wait_cnt_nx = '0;
            end
        endcase
    end

    // MEM/WB register: retire the EX/MEM op, or insert a bubble while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_data       <= '0;
            wb_en_out     <= 1'b0;
            rf_writea_out <= '0;
        end else if (mem_stall) begin
            wb_en_out <= 1'b0;
        end else begin
            unique case (em_op)
                MEMOP_LOAD: begin
                    if (timeout_hit) begin
                        wb_en_out <= 1'b0;
                    end else begin
                        wb_data       <= dmem_rdata;
                        wb_en_out     <= em_wb_en;
                        rf_writea_out <= em_rf;
                    end
                end
                MEMOP_STORE: begin
                    // A store never writes the register file.
                    if (timeout_hit) begin
                        wb_en_out <= 1'b0;
                    end else begin
                        wb_data       <= em_alu;
                        wb_en_out     <= 1'b0;
                        rf_writea_out <= em_rf;
                    end
                end
                default: begin
                    if (em_valid) begin
                        wb_data       <= em_alu;
                        wb_en_out     <= em_wb_en;
                        rf_writea_out <= em_rf;
                    end else begin
                        wb_en_out <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
